vga_sync_gen: RTL

Downstream consumer of the pixel-rate enable produced by the clock divider. Counts pixels and lines on each pixel enable and generates hsync/vsync, the visible-area flag, pixel coordinates and line/frame start strobes for the VGA pixel pipeline. Runs entirely in the 100 MHz clk domain. pix_en is a clock enable, not a derived clock.

---
 rtl/vga_timing_pkg.sv | 23 ++
 rtl/vga_axis_counter.sv | 54 +++++
 rtl/vga_sync_gen.sv | 104 ++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants shared by the VGA sync generator.
package vga_timing_pkg;

    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    // Sync active levels: 0 means the pulse is driven low.
    localparam bit VGA_H_POL = 1'b0;
    localparam bit VGA_V_POL = 1'b0;

    // Wide enough for H_TOTAL-1 (799) and V_TOTAL-1 (524).
    localparam int VGA_CNT_W = 10;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): a wrapping counter plus
// visible/sync region flags that track the counter value exactly.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE = VGA_H_VISIBLE,
    parameter int FRONT   = VGA_H_FRONT,
    parameter int SYNC    = VGA_H_SYNC,
    parameter int BACK    = VGA_H_BACK,
    parameter int W       = VGA_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         in_sync,
    output logic         in_visible
);

    localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;

    // Region edges, expressed as the count value just before each change.
    localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
    localparam logic [W-1:0] VIS_LAST = W'(VISIBLE - 1);
    localparam logic [W-1:0] SYNC_SET = W'(VISIBLE + FRONT - 1);
    localparam logic [W-1:0] SYNC_CLR = W'(VISIBLE + FRONT + SYNC - 1);

    // Terminal count on an enabled cycle; feeds the next axis and the strobes.
    assign wrap = inc && (cnt == LAST);

    // Advance the count and toggle region flags at their exact boundaries.
    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignments so every flop samples
        // pre-edge values; blocking here would create order-dependent logic.
        if (rst) begin
            cnt        <= '0;
            in_visible <= 1'b1;
            in_sync    <= 1'b0;
        end else if (inc) begin
            if (cnt == LAST) begin
                cnt        <= '0;
                in_visible <= 1'b1;
                in_sync    <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
                if (cnt == VIS_LAST) in_visible <= 1'b0;
                if (cnt == SYNC_SET) in_sync    <= 1'b1;
                if (cnt == SYNC_CLR) in_sync    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: pixel/line counters advanced by a pixel clock enable,
// with registered sync, visible-area, coordinate and start-strobe outputs.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter bit H_POL     = VGA_H_POL,
    parameter bit V_POL     = VGA_V_POL,
    parameter int CNT_W     = VGA_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start
);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic             v_inc;
    logic             h_in_sync;
    logic             v_in_sync;
    logic             h_in_vis;
    logic             v_in_vis;
    logic             line_pend;
    logic             frame_pend;

    // Lines advance only on the pixel that ends the previous line.
    assign v_inc = pix_en && h_wrap;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .W       (CNT_W)
    ) u_h_axis (
        .clk        (clk),
        .rst        (rst),
        .inc        (pix_en),
        .cnt        (h_cnt),
        .wrap       (h_wrap),
        .in_sync    (h_in_sync),
        .in_visible (h_in_vis)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .W       (CNT_W)
    ) u_v_axis (
        .clk        (clk),
        .rst        (rst),
        .inc        (v_inc),
        .cnt        (v_cnt),
        .wrap       (v_wrap),
        .in_sync    (v_in_sync),
        .in_visible (v_in_vis)
    );

    // Register the decode of the current counters every clk. A wrap is held
    // in *_pend for one clk so the strobe lands on the first output cycle
    // that shows the new (0) count, and lasts exactly one clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            video_on    <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_pend   <= 1'b0;
            frame_pend  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= h_in_sync ? H_POL : ~H_POL;
            vsync       <= v_in_sync ? V_POL : ~V_POL;
            video_on    <= h_in_vis && v_in_vis;
            x           <= h_cnt;
            y           <= v_cnt;
            line_pend   <= h_wrap;
            frame_pend  <= v_wrap;
            line_start  <= line_pend;
            frame_start <= frame_pend;
        end
    end

endmodule
